// File: rtl/mcu51_serial.sv
// MCU51 serial port, mode 1 only: 8-bit async UART (start, 8 data LSB first, stop)
// with SBUF/SCON exposed on the shared BUS through enable/output-enable strobes.
module mcu51_serial #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sbuf_en,
    input  logic       sbuf_oe,
    input  logic       scon_en,
    input  logic       scon_oe,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

    // TX_LOAD holds the latched byte for one clock so the start bit begins on the next edge
    typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shift;
    logic             tx_load, ti_set, txd_nxt;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_buf;
    logic             rx_s1, rx_s2, rx_d;
    logic             rx_sample, rx_done, rx_accept;

    logic [7:0]       scon, scon_nxt;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + 1'b1;
        tx_bit_nxt   = tx_bit;
        tx_load      = 1'b0;
        ti_set       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt = '0;
                tx_bit_nxt = '0;
                if (sbuf_en) begin
                    tx_state_nxt = TX_LOAD;
                    tx_load      = 1'b1;
                end
            end
            TX_LOAD: begin
                tx_cnt_nxt   = '0;
                tx_state_nxt = TX_START;
            end
            TX_START: if (tx_cnt == CNT_LAST) begin
                tx_cnt_nxt   = '0;
                tx_state_nxt = TX_DATA;
            end
            TX_DATA: if (tx_cnt == CNT_LAST) begin
                tx_cnt_nxt = '0;
                if (tx_bit == 3'd7) begin
                    tx_state_nxt = TX_STOP;
                    ti_set       = 1'b1;
                end else begin
                    tx_bit_nxt = tx_bit + 3'd1;
                end
            end
            TX_STOP: if (tx_cnt == CNT_LAST) tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
        case (tx_state_nxt)
            TX_START: txd_nxt = 1'b0;
            TX_DATA:  txd_nxt = tx_shift[tx_bit_nxt];
            default:  txd_nxt = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + 1'b1;
        rx_bit_nxt   = rx_bit;
        rx_sample    = 1'b0;
        rx_done      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                rx_bit_nxt = '0;
                if (rx_d && !rx_s2 && scon[4]) rx_state_nxt = RX_START;
            end
            RX_START: if (rx_cnt == CNT_HALF) begin
                rx_cnt_nxt   = '0;
                rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            end
            // the counter restarted at mid-start, so CNT_LAST lands at mid-bit
            RX_DATA: if (rx_cnt == CNT_LAST) begin
                rx_cnt_nxt = '0;
                rx_sample  = 1'b1;
                if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                else                rx_bit_nxt   = rx_bit + 3'd1;
            end
            RX_STOP: if (rx_cnt == CNT_LAST) begin
                rx_done      = 1'b1;
                rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign rx_accept = rx_done && !scon[0] && (!scon[5] || rx_s2);

    // hardware flag sets override a same-cycle software write of that flag
    always_comb begin
        scon_nxt = scon;
        if (rx_accept) scon_nxt[2] = rx_s2;
        if (scon_en)   scon_nxt    = din;
        if (ti_set)    scon_nxt[1] = 1'b1;
        if (rx_accept) scon_nxt[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            scon     <= 8'h00;
            rx_buf   <= 8'h00;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            txd      <= txd_nxt;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            scon     <= scon_nxt;
            if (rx_accept) rx_buf <= rx_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_load)   tx_shift <= din;
        if (rx_sample) rx_shift <= {rx_s2, rx_shift[7:1]};
    end

    assign irq  = scon[1] | scon[0];
    assign dout = sbuf_oe ? rx_buf : (scon_oe ? scon : 8'hzz);

endmodule

// File: tb/tb_mcu51_serial.sv
// Scoreboard bench for mcu51_serial at BAUD_DIV = 4: TX bit stream, RX framing,
// false start, overrun, SM2 filtering, REN gating, flag/write collision and reset.
module tb_mcu51_serial;
    localparam int B = 4;

    logic       clk = 1'b0;
    logic       reset, sbuf_en, sbuf_oe, scon_en, scon_oe, rxd, txd, irq;
    logic [7:0] din, dout, rd;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    mcu51_serial #(.BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset),
        .sbuf_en(sbuf_en), .sbuf_oe(sbuf_oe), .scon_en(scon_en), .scon_oe(scon_oe),
        .din(din), .dout(dout), .rxd(rxd), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_chk(input string tag, input logic [7:0] got);
        if (exp_q.size() == 0) chk({tag, "_underflow"}, 8'(exp_q.size()), 8'd1);
        else chk(tag, got, exp_q.pop_front());
    endtask

    task automatic read_reg(input logic sel_scon, output logic [7:0] v);
        if (sel_scon) scon_oe = 1'b1;
        else          sbuf_oe = 1'b1;
        #1 v = dout;
        scon_oe = 1'b0;
        sbuf_oe = 1'b0;
    endtask

    task automatic write_scon(input logic [7:0] v);
        scon_en = 1'b1;
        din     = v;
        @(negedge clk);
        scon_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (B) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (B) @(negedge clk);
        rxd = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    task automatic tx_frame(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < B; j++) exp_q.push_back({7'b0, fr[i]});
        sbuf_en = 1'b1;
        din     = b;
        @(negedge clk);
        sbuf_en = 1'b0;
        scon_oe = 1'b1;
        for (int i = 0; i < 10 * B; i++) begin
            @(negedge clk);
            sb_chk("txd_bit", {7'b0, txd});
            if (i == 9 * B - 1) chk("ti_before_stop", dout & 8'h02, 8'h00);
            if (i == 9 * B) begin
                chk("ti_at_stop", dout & 8'h02, 8'h02);
                chk("irq_tx", {7'b0, irq}, 8'h01);
            end
        end
        scon_oe = 1'b0;
    endtask

    initial begin
        reset = 1'b0; sbuf_en = 1'b0; sbuf_oe = 1'b0; scon_en = 1'b0; scon_oe = 1'b0;
        rxd = 1'b1; din = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd", {7'b0, txd}, 8'h01);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        read_reg(1'b1, rd); chk("rst_scon", rd, 8'h00);
        read_reg(1'b0, rd); chk("rst_sbuf", rd, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        tx_frame(8'hA5);
        write_scon(8'h10);
        read_reg(1'b1, rd); chk("scon_ren", rd, 8'h10);
        chk("irq_clear", {7'b0, irq}, 8'h00);

        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        read_reg(1'b1, rd); chk("rx_3c_scon", rd, 8'h15);
        chk("rx_3c_irq", {7'b0, irq}, 8'h01);
        read_reg(1'b0, rd); sb_chk("rx_3c_buf", rd);
        write_scon(8'h10);

        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (2 * B) @(negedge clk);
        read_reg(1'b1, rd); chk("false_start_scon", rd, 8'h10);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        read_reg(1'b1, rd); chk("after_glitch_scon", rd, 8'h15);
        read_reg(1'b0, rd); sb_chk("after_glitch_buf", rd);
        write_scon(8'h10);

        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        read_reg(1'b0, rd); sb_chk("ovr_first_buf", rd);
        exp_q.push_back(8'h11);
        send_byte(8'h22, 1'b1);
        read_reg(1'b0, rd); sb_chk("ovr_lost_buf", rd);
        read_reg(1'b1, rd); chk("ovr_scon", rd, 8'h15);
        write_scon(8'h10);
        exp_q.push_back(8'h33);
        send_byte(8'h33, 1'b1);
        read_reg(1'b0, rd); sb_chk("ovr_after_clear_buf", rd);

        write_scon(8'h30);
        exp_q.push_back(8'h33);
        send_byte(8'h44, 1'b0);
        read_reg(1'b1, rd); chk("sm2_bad_stop_scon", rd, 8'h30);
        read_reg(1'b0, rd); sb_chk("sm2_bad_stop_buf", rd);
        exp_q.push_back(8'h44);
        send_byte(8'h44, 1'b1);
        read_reg(1'b1, rd); chk("sm2_good_stop_scon", rd, 8'h35);
        read_reg(1'b0, rd); sb_chk("sm2_good_stop_buf", rd);

        write_scon(8'h00);
        exp_q.push_back(8'h44);
        send_byte(8'h77, 1'b1);
        read_reg(1'b1, rd); chk("ren_off_scon", rd, 8'h00);
        read_reg(1'b0, rd); sb_chk("ren_off_buf", rd);

        write_scon(8'h10);
        sbuf_en = 1'b1;
        din     = 8'hC3;
        @(negedge clk);
        sbuf_en = 1'b0;
        repeat (9 * B) @(negedge clk);
        write_scon(8'h10);
        read_reg(1'b1, rd); chk("ti_write_collide", rd, 8'h12);
        chk("ti_collide_irq", {7'b0, irq}, 8'h01);
        repeat (2 * B) @(negedge clk);

        sbuf_en = 1'b1;
        din     = 8'h00;
        @(negedge clk);
        sbuf_en = 1'b0;
        repeat (B + 2) @(negedge clk);
        chk("mid_tx_txd", {7'b0, txd}, 8'h00);
        reset = 1'b0;
        #1;
        chk("rst_mid_tx_txd", {7'b0, txd}, 8'h01);
        chk("rst_mid_tx_irq", {7'b0, irq}, 8'h00);
        read_reg(1'b1, rd); chk("rst_mid_tx_scon", rd, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (12 * B) @(negedge clk);
        chk("post_rst_txd", {7'b0, txd}, 8'h01);
        read_reg(1'b1, rd); chk("post_rst_scon", rd, 8'h00);
        read_reg(1'b0, rd); chk("post_rst_sbuf", rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mcu51_serial.md
# mcu51_serial

Serial port for the MCU51 core, implementing 8051 mode 1: 8-bit asynchronous UART with a start bit, eight data bits sent LSB first, and one stop bit. It hangs off the shared internal BUS next to the P0–P3 SFRs. It exposes SBUF and SCON through enable and output-enable strobes, as the other SFRs do, and drives the TXD and RXD pins that the MCU51 top maps onto P3.1 and P3.0. The control unit consumes its `irq` output for interrupt service.

## Interface
- `BAUD_DIV`, default 16: clocks per bit time; minimum 4; even values only.
- `clk` in 1: core clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `sbuf_en` in 1: write BUS byte `din` into the TX shift path and start a frame.
- `sbuf_oe` in 1: drive the RX buffer onto `dout`.
- `scon_en` in 1: write `din` into SCON.
- `scon_oe` in 1: drive SCON onto `dout`.
- `din` in 8: BUS data in.
- `dout` out 8: BUS data out; 8'hzz when neither oe is high. `sbuf_oe` and `scon_oe` are never high together.
- `rxd` in 1: serial input from the pin, asynchronous.
- `txd` out 1: serial output to the pin; idle high.
- `irq` out 1: TI OR RI.

## Operation
- SCON bits, MSB to LSB: SM0, SM1, SM2, REN, TB8, RB8, TI, RI.
  - SM0, SM1 and TB8 are stored and read back; they have no other effect because only mode 1 is implemented.
- Reset values: SCON = 8'h00, RX buffer = 8'h00, `txd` = 1, `irq` = 0, `dout` = z, both FSMs IDLE.
- TX FSM states: IDLE → START → DATA(0..7) → STOP → IDLE.
  - `sbuf_en` in IDLE latches `din`. START begins on the next clock.
  - Each state holds for `BAUD_DIV` clocks.
  - `txd` is 0 in START, carries data bit n in DATA(n), and is 1 in STOP and IDLE.
  - TI is set on the first clock of STOP.
  - `sbuf_en` outside IDLE is ignored; the in-flight frame is unaffected.
- RX input synchronisation: `rxd` passes through a 2-flop synchroniser; edge detection uses the synchronised value plus one more delay flop.
- RX FSM states: IDLE → START → DATA(0..7) → STOP → IDLE.
  - IDLE: a falling edge with REN = 1 enters START and clears the bit counter.
  - START: at count `BAUD_DIV`/2 − 1, if the line is high this is a false start and the FSM returns to IDLE; if low, the FSM enters DATA(0) with the counter reset.
  - DATA(n): the line is sampled at count `BAUD_DIV` − 1, i.e. mid-bit, and shifted in LSB first.
  - STOP: the line is sampled at mid-bit.
    - The byte is accepted only if RI = 0 and either SM2 = 0 or the stop bit = 1.
    - On accept: RX buffer ← byte, RB8 ← stop bit, RI ← 1.
    - Otherwise the byte is discarded and RB8 and the buffer are unchanged.
    - The FSM returns to IDLE on the same clock, so back-to-back frames are caught.
  - REN cleared mid-frame: the frame completes; no new start is accepted while REN = 0.
- Flags:
  - TI and RI are cleared only by software through `scon_en`.
  - A hardware set and a software write on the same clock: the set wins for that flag; all other bits take `din`.
- Overrun: a frame that completes while RI = 1 is lost silently.

## Timing
- `sbuf_en` at edge k: `txd` falls at edge k+1.
- The full TX frame lasts 10 × `BAUD_DIV` clocks. TI rises at edge k+1 + 9 × `BAUD_DIV`.
- RX latency from the `rxd` falling edge to RI set is 2 synchroniser clocks + 1 edge-detect clock + (`BAUD_DIV`/2 − 1) + 9 × `BAUD_DIV`, within ±1 clock.
- `dout` is combinational from the oe inputs and registered state; it is valid in the same cycle.
- `irq` is registered with the flags and tracks TI | RI with no extra delay.
- Reset low mid-frame: TX and RX abort immediately, `txd` → 1, and all state returns to its reset values. No partial byte is delivered.

## Test plan
- TX with `BAUD_DIV` = 4: write 8'hA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1 with 4 clocks per bit; TI = 1 at the start of the stop bit; `irq` = 1.
- RX with REN = 1: drive 8'h3C framed at 4 clocks per bit → RI = 1, RB8 = 1; with `sbuf_oe` high, `dout` = 8'h3C.
- False start: a 1-clock low glitch on `rxd` → RI stays 0; a frame immediately after it is received correctly.
- Overrun: receive 8'h11 and leave RI set, then receive 8'h22 → buffer still reads 8'h11. Clear RI via SCON write 8'h10, then receive 8'h33 → buffer reads 8'h33.
- SM2 = 1 with the stop bit forced low → RI stays 0 and the buffer is unchanged. The same frame with a valid stop bit → accepted.
- Simultaneous events: SCON write 8'h10 on the clock TI sets → SCON reads 8'h12. Reset asserted mid-TX → `txd` = 1 immediately and SCON = 8'h00.
